// File: rtl/imem_fetch_responder_pkg.sv
// Shared types and constants for the instruction-memory fetch responder.
package imem_fetch_responder_pkg;

  localparam logic [31:0] IMEM_NOP   = 32'h0000_0000;
  localparam int unsigned WORD_BYTES = 4;

  // Legal parameter ranges for the responder.
  localparam int unsigned LATENCY_MIN   = 1;
  localparam int unsigned LATENCY_MAX   = 4;
  localparam int unsigned RSP_DEPTH_MIN = 1;
  localparam int unsigned RSP_DEPTH_MAX = 16;

  // One fetch response as it travels through the pipeline and FIFO.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
  } imem_rsp_t;

  // True when the byte address lies beyond a memory of 2**addr_w words.
  function automatic logic addr_out_of_range(input logic [31:0] addr,
                                             input int unsigned addr_w);
    return (addr >> (addr_w + $clog2(WORD_BYTES))) != 32'h0;
  endfunction

endpackage

// File: rtl/imem_rsp_fifo.sv
// Synchronous response FIFO with flush; head is presented combinationally.
module imem_rsp_fifo
  import imem_fetch_responder_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  imem_rsp_t                  push_data,
  input  logic                       pop,
  input  logic                       flush,
  output imem_rsp_t                  head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  imem_rsp_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_en;
  logic             pop_en;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign pop_en  = pop & ~empty & ~flush;
  // A pop frees the slot being written, so push is legal even when full.
  assign push_en = push & ~flush & (~full | pop_en);

  // Next-state pointers and fill count; flush returns the FIFO to empty.
  always_comb begin
    // NOTE: every signal gets a default first so no path through this block infers a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en) wr_ptr_d = next_ptr(wr_ptr_q);
      if (pop_en)  rd_ptr_d = next_ptr(rd_ptr_q);
      count_d = count_q + CNT_W'(push_en) - CNT_W'(pop_en);
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    // NOTE: storage arrays carry no reset; validity is tracked by count/pointers alone.
    if (push_en) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/imem_fetch_responder.sv
// Instruction-memory responder: valid/ready fetch requests, fixed-latency
// pipelined read, in-order response FIFO, credit-based request throttling,
// run-time program-load port and IF flush.
module imem_fetch_responder
  import imem_fetch_responder_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned LATENCY   = 2,
  parameter int unsigned RSP_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        flush,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [31:0] rsp_addr,
  output logic        rsp_err,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data
);

  localparam int unsigned WORDS = 1 << ADDR_W;
  localparam int unsigned OCC_W = $clog2(RSP_DEPTH + 1);

  logic [31:0]         mem_q [WORDS];
  imem_rsp_t           pipe_q [LATENCY];
  logic [LATENCY-1:0]  pipe_vld_q, pipe_vld_d;
  logic [OCC_W-1:0]    occ_q, occ_d;

  logic [ADDR_W-1:0]   req_idx, ld_idx;
  logic                req_err, ld_err;
  logic                accept, pop;
  imem_rsp_t           fifo_head;
  logic                fifo_full, fifo_empty;
  logic [OCC_W-1:0]    fifo_count;
  logic                unused_ok;

  assign req_idx = req_addr[ADDR_W+1:2];
  assign ld_idx  = ld_addr[ADDR_W+1:2];
  assign req_err = addr_out_of_range(req_addr, ADDR_W);
  assign ld_err  = addr_out_of_range(ld_addr, ADDR_W);

  // Credits come from a registered count, so rsp_ready never reaches req_ready.
  assign req_ready = rst & ~flush & ~ld_valid & (occ_q < OCC_W'(RSP_DEPTH));
  assign accept    = req_valid & req_ready;
  assign rsp_valid = ~fifo_empty;
  assign pop       = rsp_valid & rsp_ready & ~flush;

  assign rsp_data  = rsp_valid ? fifo_head.data : IMEM_NOP;
  assign rsp_addr  = rsp_valid ? fifo_head.addr : 32'h0;
  assign rsp_err   = rsp_valid & fifo_head.err;

  assign unused_ok = &{1'b0, fifo_full, fifo_count, ld_addr[1:0]};

  // Next-state pipeline valids and outstanding-fetch count.
  always_comb begin
    pipe_vld_d = '0;
    occ_d      = '0;
    if (!flush) begin
      pipe_vld_d[0] = accept;
      for (int i = 1; i < LATENCY; i++) pipe_vld_d[i] = pipe_vld_q[i-1];
      occ_d = occ_q + OCC_W'(accept) - OCC_W'(pop);
    end
  end

  // Control registers; reset discards every outstanding fetch at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_vld_q <= '0;
      occ_q      <= '0;
    end else begin
      pipe_vld_q <= pipe_vld_d;
      occ_q      <= occ_d;
    end
  end

  // Program-load writes, synchronous array read and payload shift.
  always_ff @(posedge clk) begin
    if (ld_valid && !ld_err) mem_q[ld_idx] <= ld_data;
    if (accept) begin
      pipe_q[0].addr <= req_addr;
      pipe_q[0].data <= req_err ? IMEM_NOP : mem_q[req_idx];
      pipe_q[0].err  <= req_err;
    end
    for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
  end

  imem_rsp_fifo #(
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .push      (pipe_vld_q[LATENCY-1]),
    .push_data (pipe_q[LATENCY-1]),
    .pop       (pop),
    .flush     (flush),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule
